// File: rtl/knn_nat_master.sv
// knn_nat_master: native-bus initiator that programs the KNN register file for one job and reads back the label.
// Optional feature macro KNN_MASTER_TIMEOUT_EN: per-transaction m_ready timeout with sticky err.
module knn_nat_master #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int NPTS_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   test_x,
   input  logic [DATA_W-1:0]   test_y,
   input  logic [NPTS_W-1:0]   npts,
   input  logic                pt_valid,
   output logic                pt_ready,
   input  logic [DATA_W-1:0]   pt_x,
   input  logic [DATA_W-1:0]   pt_y,
   input  logic [DATA_W-1:0]   pt_label,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   xlabel,
   output logic                err,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_RST1, S_RST0, S_EN, S_WX, S_WY, S_FETCH,
      S_PX, S_PY, S_PL, S_RDL, S_FIN
   } state_t;

   state_t              state;
   state_t              next_bus;
   logic [DATA_W-1:0]   tx_r, ty_r, px_r, py_r, pl_r;
   logic [NPTS_W-1:0]   npts_r, cnt;
   logic [ADDR_W-1:0]   bus_addr;
   logic [DATA_W-1:0]   bus_data;

`ifdef KNN_MASTER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0]   wait_cnt;
`else
   assign err = 1'b0;
`endif

   // Register address, write data and successor for each bus-issuing state.
   always_comb begin
      bus_addr = '0;
      bus_data = '0;
      next_bus = S_IDLE;
      case (state)
         S_RST1: begin bus_addr = ADDR_W'(0); bus_data = DATA_W'(1); next_bus = S_RST0;  end
         S_RST0: begin bus_addr = ADDR_W'(0); bus_data = '0;         next_bus = S_EN;    end
         S_EN:   begin bus_addr = ADDR_W'(1); bus_data = DATA_W'(1); next_bus = S_WX;    end
         S_WX:   begin bus_addr = ADDR_W'(2); bus_data = tx_r;       next_bus = S_WY;    end
         S_WY:   begin bus_addr = ADDR_W'(3); bus_data = ty_r;       next_bus = S_FETCH; end
         S_PX:   begin bus_addr = ADDR_W'(4); bus_data = px_r;       next_bus = S_PY;    end
         S_PY:   begin bus_addr = ADDR_W'(5); bus_data = py_r;       next_bus = S_PL;    end
         S_PL:   begin bus_addr = ADDR_W'(6); bus_data = pl_r;       next_bus = S_FETCH; end
         S_RDL:  begin bus_addr = ADDR_W'(7); bus_data = '0;         next_bus = S_FIN;   end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pt_ready  <= 1'b0;
         xlabel    <= '0;
         m_valid   <= 1'b0;
         m_address <= '0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
         tx_r      <= '0;
         ty_r      <= '0;
         px_r      <= '0;
         py_r      <= '0;
         pl_r      <= '0;
         npts_r    <= '0;
         cnt       <= '0;
`ifdef KNN_MASTER_TIMEOUT_EN
         err       <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         pt_ready <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  tx_r   <= test_x;
                  ty_r   <= test_y;
                  npts_r <= npts;
                  cnt    <= '0;
                  busy   <= 1'b1;
`ifdef KNN_MASTER_TIMEOUT_EN
                  err    <= 1'b0;
`endif
                  state  <= S_RST1;
               end
            end
            S_FETCH: begin
               if (cnt == npts_r) begin
                  state <= S_RDL;
               end else if (pt_valid) begin
                  pt_ready <= 1'b1;
                  px_r     <= pt_x;
                  py_r     <= pt_y;
                  pl_r     <= pt_label;
                  state    <= S_PX;
               end
            end
            S_FIN: state <= S_IDLE;
            default: begin
               // Each bus state issues on entry, then holds the request until m_ready.
               if (!m_valid) begin
                  m_valid   <= 1'b1;
                  m_address <= bus_addr;
                  m_wdata   <= bus_data;
                  m_wstrb   <= (state == S_RDL) ? '0 : '1;
`ifdef KNN_MASTER_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
               end else if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= next_bus;
                  if (state == S_PL)
                     cnt <= cnt + 1'b1;
                  if (state == S_RDL) begin
                     xlabel <= m_rdata;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
               end
`ifdef KNN_MASTER_TIMEOUT_EN
               else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  m_valid <= 1'b0;
                  err     <= 1'b1;
                  xlabel  <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_FIN;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_knn_nat_master.sv
// Self-checking bench for knn_nat_master: randomized jobs against a transaction-list reference model.
module tb_knn_nat_master;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NPTS_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [DATA_W-1:0] test_x = '0, test_y = '0;
   logic [NPTS_W-1:0] npts = '0;
   logic              pt_valid = 1'b0;
   logic              pt_ready;
   logic [DATA_W-1:0] pt_x = '0, pt_y = '0, pt_label = '0;
   logic              busy, done, err;
   logic [DATA_W-1:0] xlabel;
   logic              m_valid;
   logic [ADDR_W-1:0] m_address;
   logic [DATA_W-1:0] m_wdata;
   logic [3:0]        m_wstrb;
   logic [DATA_W-1:0] m_rdata = '0;
   logic              m_ready = 1'b0;

   always #5 clk = ~clk;

   knn_nat_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPTS_W(NPTS_W), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y), .npts(npts),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_label(pt_label),
      .busy(busy), .done(done), .xlabel(xlabel), .err(err),
      .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   typedef struct { logic [31:0] x; logic [31:0] y; logic [31:0] l; } pt_t;
   typedef struct { logic [4:0] a; logic [31:0] d; logic [3:0] s; } txn_t;

   pt_t  pt_q[$];
   pt_t  job_pts[$];
   txn_t log_q[$];
   txn_t cur;

   int checks = 0;
   int errors = 0;
   int stall_cycles = 0, stall_addr = -1, long_stall = 0;
   int wcnt = 0, hold_len = 0, lim = 0;
   int done_cnt = 0, ready_cnt = 0;
   bit in_txn = 1'b0, pt_en = 1'b1;
   logic [31:0] rdata_val = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave model, point source and monitor; all driving happens on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         m_ready = 1'b0;
         in_txn  = 1'b0;
         wcnt    = 0;
      end else begin
         if (done) done_cnt++;
         if (pt_ready) begin
            ready_cnt++;
            if (pt_q.size() > 0) pt_q.delete(0);
         end
         if (m_ready) begin
            m_ready = 1'b0;
            in_txn  = 1'b0;
         end else if (!m_valid) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               cur.a = m_address; cur.d = m_wdata; cur.s = m_wstrb;
               log_q.push_back(cur);
               in_txn = 1'b1; wcnt = 0; hold_len = 0;
            end else begin
               check("hold_addr", m_address, cur.a);
               check("hold_wdata", m_wdata, cur.d);
               check("hold_wstrb", m_wstrb, cur.s);
            end
            hold_len++;
            lim = (int'(m_address) == stall_addr) ? long_stall : stall_cycles;
            if (wcnt >= lim) begin
               m_ready = 1'b1;
               m_rdata = rdata_val;
            end else begin
               wcnt++;
            end
         end
      end
      pt_valid = pt_en && (pt_q.size() > 0);
      if (pt_q.size() > 0) begin
         pt_x = pt_q[0].x; pt_y = pt_q[0].y; pt_label = pt_q[0].l;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_pt_ready"}, pt_ready, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_address"}, m_address, 0);
      check({tag, "_m_wdata"}, m_wdata, 0);
      check({tag, "_m_wstrb"}, m_wstrb, 0);
      check({tag, "_xlabel"}, xlabel, 0);
   endtask

   task automatic rand_pts(input int n);
      pt_t p;
      job_pts.delete();
      for (int i = 0; i < n; i++) begin
         p.x = $urandom; p.y = $urandom; p.l = $urandom;
         job_pts.push_back(p);
      end
   endtask

   // Expected bus traffic is the fixed preamble, three writes per point, then the label read.
   task automatic run_job(input logic [31:0] tx, input logic [31:0] ty, input logic [31:0] rd,
                          input bit restart);
      logic [4:0]  ea[$];
      logic [31:0] ed[$];
      int          n, budget, m;
      n = job_pts.size();
      log_q.delete(); pt_q.delete();
      done_cnt = 0; ready_cnt = 0; rdata_val = rd;
      ea.push_back(5'd0); ed.push_back(32'd1);
      ea.push_back(5'd0); ed.push_back(32'd0);
      ea.push_back(5'd1); ed.push_back(32'd1);
      ea.push_back(5'd2); ed.push_back(tx);
      ea.push_back(5'd3); ed.push_back(ty);
      foreach (job_pts[i]) begin
         pt_q.push_back(job_pts[i]);
         ea.push_back(5'd4); ed.push_back(job_pts[i].x);
         ea.push_back(5'd5); ed.push_back(job_pts[i].y);
         ea.push_back(5'd6); ed.push_back(job_pts[i].l);
      end
      ea.push_back(5'd7); ed.push_back(32'd0);
      @(negedge clk);
      start = 1'b1; test_x = tx; test_y = ty; npts = NPTS_W'(n);
      @(negedge clk);
      start = 1'b0; test_x = $urandom; test_y = $urandom; npts = NPTS_W'($urandom);
      check("busy_after_start", busy, 1);
      if (restart) begin
         repeat (2) @(negedge clk);
         start = 1'b1; test_x = 32'd99; npts = 8'd0;
         @(negedge clk);
         start = 1'b0;
      end
      budget = (n * 3 + 6) * 40 + 200;
      while (done_cnt == 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("done_in_time", budget > 0, 1);
      repeat (2) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("busy_end", busy, 0);
      check("xlabel", xlabel, rd);
      check("err_clear", err, 0);
      check("pt_ready_count", ready_cnt, n);
      check("txn_count", log_q.size(), ea.size());
      m = (log_q.size() < ea.size()) ? log_q.size() : ea.size();
      for (int i = 0; i < m; i++) begin
         check("txn_addr", log_q[i].a, ea[i]);
         check("txn_wstrb", log_q[i].s, (ea[i] == 5'd7) ? 4'h0 : 4'hF);
         if (ea[i] != 5'd7) check("txn_wdata", log_q[i].d, ed[i]);
      end
   endtask

   initial begin
      pt_t p;
      int  budget;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed job: test (3,4), points (1,1,5) and (9,9,7), label read returns 5.
      job_pts.delete();
      p.x = 1; p.y = 1; p.l = 5; job_pts.push_back(p);
      p.x = 9; p.y = 9; p.l = 7; job_pts.push_back(p);
      run_job(32'd3, 32'd4, 32'd5, 1'b0);

      // No training points.
      job_pts.delete();
      run_job($urandom, $urandom, 32'h2A, 1'b0);

      // Long slave stall on the XX write, and a point source that stalls in FETCH.
      stall_addr = 2; long_stall = 6; pt_en = 1'b0;
      rand_pts(2);
      fork
         run_job(32'h1234, 32'h5678, $urandom, 1'b0);
         begin
            budget = 400;
            while (!(log_q.size() == 5 && !m_valid) && budget > 0) begin
               @(negedge clk);
               budget--;
            end
            check("reach_fetch", budget > 0, 1);
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               check("fetch_stall_m_valid", m_valid, 0);
               check("fetch_stall_pt_ready", pt_ready, 0);
            end
            pt_en = 1'b1;
         end
      join
      stall_addr = -1;

      // Second start while busy must not disturb the job.
      rand_pts(1);
      run_job(32'd7, 32'd8, $urandom, 1'b1);

      for (int j = 0; j < 6; j++) begin
         stall_cycles = $urandom_range(0, 3);
         rand_pts($urandom_range(0, 6));
         run_job($urandom, $urandom, $urandom, 1'b0);
      end
      stall_cycles = 0;

      // Full-range point count.
      rand_pts(255);
      run_job($urandom, $urandom, $urandom | 32'h1, 1'b0);

      // Reset while the DATA_X write is outstanding.
      rand_pts(2);
      log_q.delete(); pt_q.delete();
      foreach (job_pts[i]) pt_q.push_back(job_pts[i]);
      stall_addr = 4; long_stall = 50;
      @(negedge clk);
      start = 1'b1; test_x = $urandom; test_y = $urandom; npts = 8'd2;
      @(negedge clk);
      start = 1'b0;
      budget = 200;
      while (!(m_valid && m_address == 5'd4) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("reach_px", budget > 0, 1);
      rst = 1'b0;
      #1;
      check_idle("abort");
      @(negedge clk);
      rst = 1'b1;
      pt_q.delete();
      stall_addr = -1;
      repeat (3) @(negedge clk);
      check_idle("after_abort");

`ifdef KNN_MASTER_TIMEOUT_EN
      // Slave never answers the ENABLE write.
      stall_addr = 1; long_stall = 1000;
      rand_pts(3);
      log_q.delete(); pt_q.delete(); done_cnt = 0;
      foreach (job_pts[i]) pt_q.push_back(job_pts[i]);
      @(negedge clk);
      start = 1'b1; test_x = $urandom; test_y = $urandom; npts = 8'd3;
      @(negedge clk);
      start = 1'b0;
      budget = 200;
      while (done_cnt == 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("timeout_done_in_time", budget > 0, 1);
      repeat (2) @(negedge clk);
      check("timeout_err", err, 1);
      check("timeout_xlabel", xlabel, 0);
      check("timeout_done_once", done_cnt, 1);
      check("timeout_hold_len", hold_len, 8);
      check("timeout_txn_count", log_q.size(), 3);
      check("timeout_m_valid", m_valid, 0);
      stall_addr = -1;
      rand_pts(1);
      run_job($urandom, $urandom, $urandom, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
